// File: rtl/adc_config_cmdq_if.sv
// AXI4-Lite subordinate bundle for the ADC config/command block.
// Master drives requests, slave returns ready/response.
`timescale 1ns/1ps
interface adc_config_cmdq_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arprot, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );
endinterface

// File: rtl/adc_config_cmdq.sv
// ADC front-end register block: CFG words, status, and a
// host command FIFO streamed out over AXI-Stream.
`timescale 1ns/1ps
module adc_config_cmdq #(
  parameter int NUM_CFG    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  adc_config_cmdq_if.slave       s_axi_lite,
  output logic [32*NUM_CFG-1:0]  cfg_o,
  input  logic [31:0]            status_i,
  output logic                   adc_resetn_o,
  output logic                   dma_resetn_o,
  output logic                   packetizer_resetn_o,
  output logic [4:0]             en_o,
  output logic [31:0]            m_axis_tdata_o,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic int cfg_word(input int k);
    return (k == 0) ? 0 : k + 3;
  endfunction

  function automatic logic is_cfg(input int i);
    return (i == 0) || (i >= 4 && i < NUM_CFG + 3);
  endfunction

  function automatic logic [31:0] bmask(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    aw_got_q, aw_got_d;
  logic                    w_got_q, w_got_d;
  logic [IW-1:0]           awaddr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [NUM_CFG-1:0][31:0] cfg_q, cfg_d;
  logic [31:0]             mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wptr_q, rptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;

  logic          aw_fire, w_fire, ar_fire;
  logic          aw_have, w_have, wr_commit;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [31:0]   wr_data, qstat;
  logic [3:0]    wr_strb;
  int            wr_i, rd_i;
  logic          full, empty, pop, push;
  logic          cmd_req, ovf_set, qclr;

  assign full  = count_q == CW'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign pop   = !empty && m_axis_tready_i;
  assign qstat = {ovf_q, 13'd0, full, empty, 16'(count_q)};

  always_comb begin
    aw_fire   = s_axi_lite.awvalid && awready_q;
    w_fire    = s_axi_lite.wvalid && wready_q;
    aw_have   = aw_got_q || aw_fire;
    w_have    = w_got_q || w_fire;
    wr_commit = aw_have && w_have;
    wr_idx    = aw_fire ? s_axi_lite.awaddr[ADDR_WIDTH-1:2]
                        : awaddr_q;
    wr_data   = w_fire ? s_axi_lite.wdata : wdata_q;
    wr_strb   = w_fire ? s_axi_lite.wstrb : wstrb_q;
    wr_i      = int'(wr_idx);
    aw_got_d  = aw_have && !wr_commit;
    w_got_d   = w_have && !wr_commit;
    bvalid_d  = wr_commit || (bvalid_q && !s_axi_lite.bready);
    // Readies stay low from own handshake until B completes.
    awready_d = !aw_got_d && !bvalid_d;
    wready_d  = !w_got_d && !bvalid_d;
  end

  always_comb begin
    cmd_req = wr_commit && (wr_i == 2);
    push    = cmd_req && (!full || pop);
    ovf_set = cmd_req && full && !pop;
    qclr    = wr_commit && (wr_i == 3)
              && wr_strb[3] && wr_data[31];
    ovf_d   = ovf_set || (ovf_q && !qclr);
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    bresp_d = bresp_q;
    if (wr_commit) begin
      if (!(wr_i <= 3 || is_cfg(wr_i)) || wr_i == 1 || ovf_set)
        bresp_d = SLVERR;
      else
        bresp_d = OKAY;
    end
    cfg_d = cfg_q;
    for (int k = 0; k < NUM_CFG; k++)
      if (wr_commit && wr_i == cfg_word(k))
        cfg_d[k] = bmask(cfg_q[k], wr_data, wr_strb);
  end

  always_comb begin
    ar_fire   = s_axi_lite.arvalid && arready_q;
    rvalid_d  = ar_fire || (rvalid_q && !s_axi_lite.rready);
    arready_d = !rvalid_d;
    rd_idx    = s_axi_lite.araddr[ADDR_WIDTH-1:2];
    rd_i      = int'(rd_idx);
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_fire) begin
      rdata_d = '0;
      rresp_d = OKAY;
      unique case (1'b1)
        rd_i == 1:    rdata_d = status_i;
        rd_i == 2:    rdata_d = '0;
        rd_i == 3:    rdata_d = qstat;
        is_cfg(rd_i): begin
          for (int k = 0; k < NUM_CFG; k++)
            if (rd_i == cfg_word(k)) rdata_d = cfg_q[k];
        end
        default:      rresp_d = SLVERR;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      cfg_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      if (aw_fire) awaddr_q <= s_axi_lite.awaddr[ADDR_WIDTH-1:2];
      if (w_fire) begin
        wdata_q <= s_axi_lite.wdata;
        wstrb_q <= s_axi_lite.wstrb;
      end
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      cfg_q     <= cfg_d;
      if (push) begin
        mem_q[wptr_q] <= wr_data;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign s_axi_lite.awready = awready_q;
  assign s_axi_lite.wready  = wready_q;
  assign s_axi_lite.bvalid  = bvalid_q;
  assign s_axi_lite.bresp   = bresp_q;
  assign s_axi_lite.arready = arready_q;
  assign s_axi_lite.rvalid  = rvalid_q;
  assign s_axi_lite.rdata   = rdata_q;
  assign s_axi_lite.rresp   = rresp_q;

  assign cfg_o               = cfg_q;
  assign adc_resetn_o        = cfg_q[0][0] & aresetn;
  assign dma_resetn_o        = cfg_q[0][1] & aresetn;
  assign packetizer_resetn_o = cfg_q[0][2] & aresetn;
  assign en_o                = cfg_q[0][7:3];
  assign m_axis_tdata_o      = mem_q[rptr_q];
  assign m_axis_tvalid_o     = !empty;

  logic unused_bits;
  assign unused_bits = ^{s_axi_lite.awprot, s_axi_lite.arprot,
                         s_axi_lite.awaddr[31:ADDR_WIDTH],
                         s_axi_lite.awaddr[1:0],
                         s_axi_lite.araddr[31:ADDR_WIDTH],
                         s_axi_lite.araddr[1:0]};

endmodule

// File: tb/tb_adc_config_cmdq.sv
// Scoreboard bench for adc_config_cmdq: B/R/stream
// responses are queued at stimulus time and checked on handshake.
`timescale 1ns/1ps
module tb_adc_config_cmdq;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  adc_config_cmdq_if bus ();
  logic [63:0] cfg;
  logic [31:0] status;
  logic        adc_rn, dma_rn, pkt_rn;
  logic [4:0]  en;
  logic [31:0] tdata;
  logic        tvalid, tready;

  adc_config_cmdq #(
    .NUM_CFG(2), .FIFO_DEPTH(8), .ADDR_WIDTH(8)
  ) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .s_axi_lite          (bus.slave),
    .cfg_o               (cfg),
    .status_i            (status),
    .adc_resetn_o        (adc_rn),
    .dma_resetn_o        (dma_rn),
    .packetizer_resetn_o (pkt_rn),
    .en_o                (en),
    .m_axis_tdata_o      (tdata),
    .m_axis_tvalid_o     (tvalid),
    .m_axis_tready_i     (tready)
  );

  int n_run = 0;
  int n_fail = 0;
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [31:0] exp_s [$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 1, 0);
        else check("bresp", 32'(bus.bresp), 32'(exp_b.pop_front()));
      end
      if (bus.rvalid && bus.rready) begin
        logic [33:0] e;
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else begin
          e = exp_r.pop_front();
          check("rdata", bus.rdata, e[31:0]);
          check("rresp", 32'(bus.rresp), 32'(e[33:32]));
        end
      end
      if (tvalid && tready) begin
        if (exp_s.size() == 0) check("s_unexpected", 1, 0);
        else check("tdata", tdata, exp_s.pop_front());
      end
    end
  end

  task automatic aw_phase(input logic [31:0] a);
    bit ok = 0;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (bus.awready) begin ok = 1; break; end
    end
    if (!ok) check("aw_timeout", 0, 1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (bus.wready) begin ok = 1; break; end
    end
    if (!ok) check("w_timeout", 0, 1);
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_b();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (bus.bvalid) begin ok = 1; break; end
    end
    if (!ok) check("b_timeout", 0, 1);
    @(posedge aclk); #1;
  endtask

  // mode 0: AW+W together, 1: W leads by two cycles, 2: AW leads
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int mode,
                    input logic [1:0] er);
    exp_b.push_back(er);
    case (mode)
      1: fork
           w_phase(d, s);
           begin repeat (2) @(posedge aclk); #1; aw_phase(a); end
         join
      2: fork
           aw_phase(a);
           begin repeat (2) @(posedge aclk); #1; w_phase(d, s); end
         join
      default: fork
           aw_phase(a);
           w_phase(d, s);
         join
    endcase
    wait_b();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] er);
    bit ok = 0;
    exp_r.push_back({er, d});
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (bus.arready) begin ok = 1; break; end
    end
    if (!ok) check("ar_timeout", 0, 1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (bus.rvalid) begin ok = 1; break; end
    end
    if (!ok) check("r_timeout", 0, 1);
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    tready = 1'b0;
    status = 32'hA5A5_0001;

    repeat (5) @(posedge aclk); #1;
    check("rst_cfg_lo", cfg[31:0], 0);
    check("rst_cfg_hi", cfg[63:32], 0);
    check("rst_resets", 32'({adc_rn, dma_rn, pkt_rn}), 0);
    check("rst_en", 32'(en), 0);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_bvalid", 32'(bus.bvalid), 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("rdy_after_rst",
          32'({bus.awready, bus.wready, bus.arready}), 32'h7);
    rd(32'h0C, 32'h0001_0000, OKAY);
    rd(32'h04, 32'hA5A5_0001, OKAY);
    rd(32'h00, 32'h0, OKAY);

    wr(32'h00, 32'h0000_0007, 4'hF, 0, OKAY);
    check("m0_resets", 32'({adc_rn, dma_rn, pkt_rn}), 32'h7);
    check("m0_en", 32'(en), 0);
    wr(32'h00, 32'h0000_00F8, 4'hF, 1, OKAY);
    check("m1_resets", 32'({adc_rn, dma_rn, pkt_rn}), 0);
    check("m1_en", 32'(en), 32'h1F);
    wr(32'h00, 32'h1234_56FF, 4'hF, 2, OKAY);
    check("m2_resets", 32'({adc_rn, dma_rn, pkt_rn}), 32'h7);
    check("m2_en", 32'(en), 32'h1F);
    rd(32'h00, 32'h1234_56FF, OKAY);
    wr(32'h00, 32'h0000_0000, 4'b0001, 0, OKAY);
    check("strb_cfg0", cfg[31:0], 32'h1234_5600);
    check("strb_en", 32'(en), 0);
    wr(32'h00, 32'h0000_00FF, 4'hF, 0, OKAY);

    wr(32'h04, 32'hFFFF_FFFF, 4'hF, 0, SLVERR);
    wr(32'h3C, 32'h0000_0001, 4'hF, 1, SLVERR);
    check("err_cfg0", cfg[31:0], 32'h0000_00FF);
    check("err_cfg1", cfg[63:32], 0);
    rd(32'h3C, 32'h0, SLVERR);
    rd(32'h08, 32'h0, OKAY);
    wr(32'h10, 32'hDEAD_BEEF, 4'hF, 2, OKAY);
    check("cfg1", cfg[63:32], 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF, OKAY);
    rd(32'h14, 32'h0, SLVERR);

    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) begin
        exp_s.push_back(32'(i));
        wr(32'h08, 32'(i), 4'h0, i % 3, OKAY);
      end else begin
        wr(32'h08, 32'(i), 4'h0, 0, SLVERR);
      end
    end
    check("full_tvalid", 32'(tvalid), 1);
    check("full_head", tdata, 32'h1);
    rd(32'h0C, 32'h8002_0008, OKAY);
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_tvalid", 32'(tvalid), 1);
      @(posedge aclk); #1;
    end
    check("drained_tvalid", 32'(tvalid), 0);
    tready = 1'b0;
    rd(32'h0C, 32'h8001_0000, OKAY);
    wr(32'h0C, 32'h8000_0000, 4'hF, 0, OKAY);
    rd(32'h0C, 32'h0001_0000, OKAY);

    for (int i = 0; i < 8; i++) begin
      exp_s.push_back(32'h100 + 32'(i));
      wr(32'h08, 32'h100 + 32'(i), 4'hF, 0, OKAY);
    end
    rd(32'h0C, 32'h0002_0008, OKAY);
    exp_b.push_back(OKAY);
    exp_s.push_back(32'h1FF);
    bus.awaddr = 32'h08; bus.wdata = 32'h1FF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; tready = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; tready = 1'b0;
    wait_b();
    rd(32'h0C, 32'h0002_0008, OKAY);
    tready = 1'b1;
    repeat (9) @(posedge aclk); #1;
    tready = 1'b0;
    check("pp_drained", 32'(tvalid), 0);
    check("pp_s_empty", 32'(exp_s.size()), 0);

    for (int i = 0; i < 3; i++) begin
      exp_s.push_back(32'h21 + 32'(i));
      wr(32'h08, 32'h21 + 32'(i), 4'hF, 0, OKAY);
    end
    check("pre_rst_adc", 32'(adc_rn), 1);
    bus.bready = 1'b0;
    fork
      aw_phase(32'h10);
      w_phase(32'h0000_0055, 4'hF);
    join
    @(negedge aclk);
    check("b_pending", 32'(bus.bvalid), 1);
    #2 aresetn = 1'b0;
    #1;
    check("mr_tvalid", 32'(tvalid), 0);
    check("mr_bvalid", 32'(bus.bvalid), 0);
    check("mr_adc_rn", 32'(adc_rn), 0);
    check("mr_en", 32'(en), 0);
    exp_s.delete();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    rd(32'h0C, 32'h0001_0000, OKAY);
    rd(32'h10, 32'h0, OKAY);

    repeat (3) @(posedge aclk); #1;
    check("end_b_q", 32'(exp_b.size()), 0);
    check("end_r_q", 32'(exp_r.size()), 0);
    check("end_s_q", 32'(exp_s.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
